prm_oblgc_scan: RTL and testbench

Range sequencer for the PRM obstacle-logic checkers (`prm_oblgc_chkNNN`). Once started, it walks a contiguous range of 15-bit edge codes and presents one code per cycle on bits A..O of a combinational checker. It samples the checker's `edge_mask` reply and packs the replies into 32-bit mask words, delivered through a valid/ready stream to the roadmap edge-mask RAM writer. It also counts masked edges and signals completion to the planner controller.

---
 rtl/prm_oblgc_scan.sv | 129 ++++++++++++
 tb/tb_prm_oblgc_scan.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/prm_oblgc_scan.sv
`default_nettype none
// prm_oblgc_scan: walks an inclusive edge-code range through a combinational
// obstacle checker and packs its edge_mask replies into words on a valid/ready stream.
module prm_oblgc_scan #(
  parameter int CODE_W = 15,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [CODE_W-1:0] start_code,
  input  logic [CODE_W-1:0] end_code,
  output logic [CODE_W-1:0] chk_code,
  input  logic              chk_mask,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic [ADDR_W-1:0] word_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CODE_W:0]   hit_count
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CODE_W-1:0] end_r;
  logic [IDX_W-1:0]  bit_idx;
  logic              last;

  logic range_bad;
  logic scan_end;
  logic at_end;

  assign range_bad = (end_code < start_code);
  assign at_end    = (chk_code == end_r);
  assign scan_end  = (bit_idx == IDX_W'(WORD_W - 1)) || at_end;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    word_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = range_bad ? DONE : SCAN;
      end
      SCAN: begin
        if (scan_end) state_nx = EMIT;
      end
      EMIT: begin
        word_valid = 1'b1;
        if (word_ready) state_nx = last ? DONE : SCAN;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // word_data is the pack register itself, so it holds steady across an EMIT stall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      chk_code  <= '0;
      end_r     <= '0;
      bit_idx   <= '0;
      last      <= 1'b0;
      word_data <= '0;
      word_addr <= '0;
      err       <= 1'b0;
      hit_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            end_r     <= end_code;
            bit_idx   <= '0;
            last      <= 1'b0;
            word_data <= '0;
            word_addr <= '0;
            hit_count <= '0;
            err       <= range_bad;
            if (!range_bad) chk_code <= start_code;
          end
        end
        SCAN: begin
          word_data[bit_idx] <= chk_mask;
          hit_count          <= hit_count + (CODE_W+1)'(chk_mask);
          if (scan_end) begin
            last <= at_end;
          end else begin
            chk_code <= chk_code + CODE_W'(1);
            bit_idx  <= bit_idx + IDX_W'(1);
          end
        end
        EMIT: begin
          if (word_ready) begin
            word_data <= '0;
            bit_idx   <= '0;
            word_addr <= word_addr + ADDR_W'(1);
            // The final code is never incremented, so chk_code cannot wrap past the top.
            if (!last) chk_code <= chk_code + CODE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prm_oblgc_scan.sv
`default_nettype none
// Scoreboard bench for prm_oblgc_scan: a behavioural checker stub feeds chk_mask,
// expected words are queued at start and compared as the DUT hands them over.
module tb_prm_oblgc_scan;
  localparam int CODE_W = 15;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 10;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic [CODE_W-1:0] start_code = '0;
  logic [CODE_W-1:0] end_code = '0;
  logic [CODE_W-1:0] chk_code;
  logic              chk_mask;
  logic              word_valid;
  logic              word_ready = 1'b1;
  logic [WORD_W-1:0] word_data;
  logic [ADDR_W-1:0] word_addr;
  logic              busy;
  logic              done;
  logic              err;
  logic [CODE_W:0]   hit_count;

  int vectors = 0;
  int miscompares = 0;
  int mode = 0;
  logic seen_zero;

  typedef struct {
    logic [WORD_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } exp_t;
  exp_t q[$];

  prm_oblgc_scan #(.CODE_W(CODE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .start_code(start_code), .end_code(end_code),
    .chk_code(chk_code), .chk_mask(chk_mask), .word_valid(word_valid),
    .word_ready(word_ready), .word_data(word_data), .word_addr(word_addr),
    .busy(busy), .done(done), .err(err), .hit_count(hit_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic mask_of(input int m, input logic [CODE_W-1:0] c);
    case (m)
      0:       return c[0];
      1:       return 1'b1;
      default: return c[0] ^ c[3] ^ c[7];
    endcase
  endfunction

  assign chk_mask = mask_of(mode, chk_code);

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake completes on the next rising edge; ready is only changed just after rising edges.
  always @(negedge CLK) begin
    if (!RST && word_valid && word_ready) begin
      if (q.size() == 0) begin
        check_val("word_extra", word_valid, 0);
      end else begin
        exp_t w;
        w = q.pop_front();
        check_val("word_data", word_data, w.data);
        check_val("word_addr", word_addr, w.addr);
      end
    end
  end

  task automatic run_scan(input int s, input int e, input int stall, input int restart_at,
                          output int cyc);
    int n, left, hits;
    logic saw_valid, snapped;
    logic [WORD_W-1:0] sd;
    logic [CODE_W-1:0] sc;
    logic [CODE_W:0]   sh;
    exp_t w;
    n = (e >= s) ? e - s + 1 : 0;
    hits = 0;
    for (int k = 0; k * WORD_W < n; k++) begin
      w.data = '0;
      w.addr = ADDR_W'(k);
      for (int i = 0; i < WORD_W; i++)
        if (k * WORD_W + i < n) w.data[i] = mask_of(mode, CODE_W'(s + k * WORD_W + i));
      q.push_back(w);
    end
    for (int c = s; c <= e; c++) hits += int'(mask_of(mode, CODE_W'(c)));

    start = 1'b1;
    start_code = CODE_W'(s);
    end_code = CODE_W'(e);
    @(posedge CLK); #1;
    start = 1'b0;
    start_code = ~start_code;
    end_code = ~end_code;
    cyc = 0;
    saw_valid = 1'b0;
    snapped = 1'b0;
    seen_zero = 1'b0;
    left = stall;
    while (!done && cyc < 4000) begin
      if (word_valid) saw_valid = 1'b1;
      if (chk_code == '0) seen_zero = 1'b1;
      if (cyc == restart_at) begin
        start = 1'b1;
        start_code = '0;
        end_code = CODE_W'(1);
      end else begin
        start = 1'b0;
      end
      if (word_valid && left > 0) begin
        if (!snapped) begin
          sd = word_data; sc = chk_code; sh = hit_count; snapped = 1'b1;
        end else begin
          check_val("stall_data", word_data, sd);
          check_val("stall_code", chk_code, sc);
          check_val("stall_hits", hit_count, sh);
        end
        word_ready = 1'b0;
        left--;
      end else begin
        word_ready = 1'b1;
      end
      @(posedge CLK); #1;
      cyc++;
    end
    start = 1'b0;
    word_ready = 1'b1;
    check_val("done_seen", done, 1);
    check_val("done_edge", cyc + 1, n + (n + WORD_W - 1) / WORD_W + 1 + stall);
    check_val("hit_count", hit_count, hits);
    check_val("err", err, (n == 0));
    if (n == 0) check_val("no_valid", saw_valid, 0);
    check_val("words_left", q.size(), 0);
    @(posedge CLK); #1;
    check_val("done_pulse", done, 0);
    check_val("busy_idle", busy, 0);
    check_val("err_held", err, (n == 0));
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_code"},  chk_code, 0);
    check_val({tag, "_valid"}, word_valid, 0);
    check_val({tag, "_data"},  word_data, 0);
    check_val({tag, "_addr"},  word_addr, 0);
    check_val({tag, "_busy"},  busy, 0);
    check_val({tag, "_done"},  done, 0);
    check_val({tag, "_err"},   err, 0);
    check_val({tag, "_hits"},  hit_count, 0);
  endtask

  initial begin
    int c0, c1;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals("rst");
    RST = 1'b0;
    @(posedge CLK); #1;

    mode = 0;
    run_scan(0, 31, 0, -1, c0);
    run_scan(0, 39, 0, -1, c0);
    run_scan(100, 131, 0, -1, c0);
    run_scan(100, 131, 5, -1, c1);
    check_val("stall_delay", c1, c0 + 5);
    run_scan(10, 9, 0, -1, c0);

    mode = 1;
    run_scan(32'h7FE0, 32'h7FFF, 0, -1, c0);
    check_val("no_wrap", seen_zero, 0);

    mode = 2;
    run_scan(5, 100, 2, -1, c0);

    // Abort a scan at bit 12, then rerun it with a stray start mid-scan.
    start = 1'b1; start_code = CODE_W'(200); end_code = CODE_W'(263);
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    check_val("abort_code", chk_code, 212);
    check_val("abort_busy", busy, 1);
    RST = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(posedge CLK); #1;
    check_val("midrst_nodone", done, 0);
    RST = 1'b0;
    @(posedge CLK); #1;
    run_scan(200, 263, 0, 5, c0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
